bottomhalf_cmd_sched: RTL and testbench

Command scheduler for FPGA bottom-half bitfiles. It accepts command bytes written by the host over the latched-address data bus and queues them in a small FIFO. It dispatches them one at a time to the payload command engine, waits for completion, then enforces an optional per-command post-delay before dispatching the next. It replaces the single-slot run/finish toggle handshake, so the host can stream several commands without polling between them.

---
 rtl/bottomhalf_cmd_sched.sv | 135 +++++++++++++
 tb/tb_bottomhalf_cmd_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bottomhalf_cmd_sched.sv
// Queued command scheduler: FIFO of host commands, dispatch/run/post-delay FSM.
// Optional command watchdog compiled in with CMD_SCHED_TIMEOUT_EN.
module bottomhalf_cmd_sched #(
  parameter int DEPTH      = 4,
  parameter int OSC_MHZ    = 24,
  parameter int TIMEOUT_US = 2730
) (
  input  logic                     osc_signal,
  input  logic                     rst,
  input  logic                     wr_stb,
  input  logic [7:0]               wr_data,
  input  logic                     flush_stb,
  input  logic                     err_clr_stb,
  output logic                     cmd_start,
  output logic [3:0]               cmd_nr,
  input  logic                     cmd_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     timeout,
  output logic [7:0]               status
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (1 << AW) != DEPTH || TIMEOUT_US < 1)
    $error("bottomhalf_cmd_sched: bad parameters");

  typedef enum logic [1:0] {IDLE, START, RUN, POSTDLY} state_t;

  state_t      state;
  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [3:0]  code;
  logic [15:0] dly;
  logic [7:0]  head;
  logic        full, pop, push, drop;
  logic        to_set, fin, active_n;
  logic        ov_n, to_n;
  logic [AW:0] level_n;
  logic [3:0]  lvl4;

`ifdef CMD_SCHED_TIMEOUT_EN
  localparam int WD_LOAD = TIMEOUT_US * OSC_MHZ - 1;
  localparam int WDW     = $clog2(TIMEOUT_US * OSC_MHZ + 1);
  logic [WDW-1:0] wd;
`endif

  always_comb begin
    head    = mem[rp];
    full    = fifo_level == (AW+1)'(DEPTH);
    pop     = (state == IDLE) && (fifo_level != '0);
    push    = wr_stb && !flush_stb && (!full || pop);
    drop    = wr_stb && !flush_stb && full && !pop;
    level_n = flush_stb ? '0
            : fifo_level + (AW+1)'(push) - (AW+1)'(pop);
`ifdef CMD_SCHED_TIMEOUT_EN
    to_set  = (state == RUN) && !cmd_done && (wd == '0);
`else
    to_set  = 1'b0;
`endif
    fin      = ((state == RUN) && cmd_done && (code == 4'd0))
            || ((state == POSTDLY) && (dly == 16'd0))
            || to_set;
    active_n = (state == IDLE) ? pop : !fin;
    // Error set wins over a same-cycle clear.
    ov_n = drop   | (overflow & ~err_clr_stb);
    to_n = to_set | (timeout  & ~err_clr_stb);
    lvl4 = 4'(level_n);
  end

  always_ff @(posedge osc_signal) begin
    if (push) mem[wp] <= wr_data;
  end

  always_ff @(posedge osc_signal) begin
    if (rst) begin
      state      <= IDLE;
      cmd_start  <= 1'b0;
      cmd_nr     <= 4'd0;
      code       <= 4'd0;
      dly        <= 16'd0;
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      status     <= 8'd0;
`ifdef CMD_SCHED_TIMEOUT_EN
      wd         <= '0;
`endif
    end else begin
      wp <= flush_stb ? '0 : (push ? wp + AW'(1) : wp);
      rp <= flush_stb ? '0 : (pop  ? rp + AW'(1) : rp);
      fifo_level <= level_n;
      overflow   <= ov_n;
      timeout    <= to_n;
      busy       <= active_n || (level_n != '0);
      status     <= {ov_n, to_n, active_n || (level_n != '0), 1'b0, lvl4};
      cmd_start  <= 1'b0;
      unique case (state)
        IDLE: if (pop) begin
          cmd_nr    <= head[3:0];
          code      <= head[7:4];
          cmd_start <= 1'b1;
          state     <= START;
        end
        START: begin
          state <= RUN;
`ifdef CMD_SCHED_TIMEOUT_EN
          wd    <= WDW'(WD_LOAD);
`endif
        end
        RUN: if (cmd_done) begin
          if (code == 4'd0) state <= IDLE;
          else begin
            dly   <= 16'(int'(code) * 16 * OSC_MHZ - 1);
            state <= POSTDLY;
          end
        end
`ifdef CMD_SCHED_TIMEOUT_EN
        else if (wd == '0) state <= IDLE;
        else wd <= wd - WDW'(1);
`endif
        POSTDLY: begin
          if (dly == 16'd0) state <= IDLE;
          else dly <= dly - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bottomhalf_cmd_sched.sv
// Directed bench for bottomhalf_cmd_sched (DEPTH=4, 24 MHz, TIMEOUT_US=1).
module tb_bottomhalf_cmd_sched;

  logic       clk = 1'b0;
  logic       rst, wr_stb, flush_stb, err_clr_stb, cmd_done;
  logic [7:0] wr_data;
  logic       cmd_start, busy, overflow, timeout;
  logic [3:0] cmd_nr;
  logic [2:0] fifo_level;
  logic [7:0] status;

  int errors = 0;
  int checks = 0;
  int cnt;

  always #5 clk = ~clk;

  bottomhalf_cmd_sched #(.DEPTH(4), .OSC_MHZ(24), .TIMEOUT_US(1)) dut (
    .osc_signal(clk), .rst(rst), .wr_stb(wr_stb), .wr_data(wr_data),
    .flush_stb(flush_stb), .err_clr_stb(err_clr_stb),
    .cmd_start(cmd_start), .cmd_nr(cmd_nr), .cmd_done(cmd_done),
    .busy(busy), .fifo_level(fifo_level), .overflow(overflow),
    .timeout(timeout), .status(status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_stb = 1'b1;
    wr_data = d;
    tick();
    wr_stb = 1'b0;
  endtask

  task automatic done();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_stb = 0; wr_data = 0;
    flush_stb = 0; err_clr_stb = 0; cmd_done = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_start", int'(cmd_start), 0);
    chk("rst_nr", int'(cmd_nr), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_status", int'(status), 0);

    // single command, 2-cycle dispatch latency
    push(8'h03);
    chk("p1_level", int'(fifo_level), 1);
    chk("p1_nostart", int'(cmd_start), 0);
    chk("p1_busy", int'(busy), 1);
    tick();
    chk("p1_start", int'(cmd_start), 1);
    chk("p1_nr", int'(cmd_nr), 3);
    chk("p1_level0", int'(fifo_level), 0);
    tick();
    chk("p1_pulse", int'(cmd_start), 0);
    done();
    chk("p1_idle", int'(busy), 0);
    chk("p1_status", int'(status), 0);

    // post-delay of 2*16*24 cycles between commands
    push(8'h21);
    push(8'h05);
    chk("pd_start1", int'(cmd_start), 1);
    chk("pd_nr1", int'(cmd_nr), 1);
    chk("pd_level", int'(fifo_level), 1);
    tick();
    done();
    chk("pd_status", int'(status), 8'h21);
    cnt = 0;
    while (!cmd_start && cnt < 2000) begin
      tick();
      cnt++;
    end
    chk("pd_gap", cnt, 769);
    chk("pd_nr2", int'(cmd_nr), 5);
    tick();
    done();
    chk("pd_idle", int'(busy), 0);

    // overflow with cmd_done withheld
    for (int i = 1; i <= 6; i++) push(8'(i));
    chk("ov_level", int'(fifo_level), 4);
    chk("ov_flag", int'(overflow), 1);
    chk("ov_status", int'(status), 8'hA4);
    chk("ov_nr", int'(cmd_nr), 1);
    err_clr_stb = 1'b1;
    tick();
    err_clr_stb = 1'b0;
    chk("ov_clr", int'(overflow), 0);
    chk("ov_keep", int'(fifo_level), 4);

    // flush beats a same-cycle write
    done();
    tick(); tick();
    chk("fl_pre", int'(fifo_level), 3);
    chk("fl_nr", int'(cmd_nr), 2);
    flush_stb = 1'b1;
    wr_stb = 1'b1;
    wr_data = 8'h09;
    tick();
    flush_stb = 1'b0;
    wr_stb = 1'b0;
    chk("fl_level", int'(fifo_level), 0);
    chk("fl_ovf", int'(overflow), 0);
    chk("fl_run", int'(busy), 1);
    done();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_start) cnt++;
    end
    chk("fl_nostart", cnt, 0);
    chk("fl_idle", int'(busy), 0);

`ifdef CMD_SCHED_TIMEOUT_EN
    push(8'h01);
    tick(); tick();
    cnt = 0;
    while (!timeout && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("to_cycles", cnt, 24);
    chk("to_idle", int'(busy), 0);
    chk("to_status", int'(status), 8'h40);
    err_clr_stb = 1'b1;
    tick();
    err_clr_stb = 1'b0;
    chk("to_clr", int'(timeout), 0);
`else
    chk("to_tied", int'(timeout), 0);
`endif

    // reset during post-delay
    push(8'h17);
    tick(); tick();
    done();
    tick(); tick();
    chk("rp_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rp_start", int'(cmd_start), 0);
    chk("rp_nr", int'(cmd_nr), 0);
    chk("rp_busy0", int'(busy), 0);
    chk("rp_status", int'(status), 0);
    done();
    chk("rp_late_busy", int'(busy), 0);
    chk("rp_late_start", int'(cmd_start), 0);
    chk("rp_late_level", int'(fifo_level), 0);
    chk("rp_late_to", int'(timeout), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
